// File: rtl/riscv_pkg.sv
//==============================================================================
// riscv_pkg : RV32I opcode constants, format enum and field bundle type.
// Rev 1.0
//==============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [2:0] F3_SLLI   = 3'b001;
  localparam logic [2:0] F3_SRXI   = 3'b101;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                       f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   f = FMT_I;
      OP_STORE:                   f = FMT_S;
      OP_BRANCH:                  f = FMT_B;
      OP_LUI, OP_AUIPC:           f = FMT_U;
      OP_JAL:                     f = FMT_J;
      default:                    f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

  function automatic logic is_shift_imm(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_IMM) && ((f3 == F3_SLLI) || (f3 == F3_SRXI));
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_encoder_if.sv
//==============================================================================
// inst_encoder_if : field-bundle handshake and instruction-memory write port.
// Rev 1.0
//==============================================================================
`default_nettype none

interface inst_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Program-load source side: drives fields, observes ready and the memory port.
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/inst_pack.sv
//==============================================================================
// inst_pack : combinational RV32I format select, bit packing, immediate check.
// Optional macro IMM_RANGE_CHECK_EN rejects unrepresentable immediates.
// Rev 1.0
//==============================================================================
`default_nettype none

module inst_pack
  import riscv_pkg::*;
(
  input  fields_t     fields_i,
  output logic [31:0] word_o,
  output logic        reject_o
);

  fmt_e        w_fmt;
  logic        w_shift;
  logic        w_imm_ok;
  logic [31:0] w_imm;

  assign w_fmt   = opcode_fmt(fields_i.opcode);
  assign w_shift = is_shift_imm(fields_i.opcode, fields_i.funct3);
  assign w_imm   = fields_i.imm;

  always_comb begin
    word_o = '0;
    case (w_fmt)
      FMT_R: word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                       fields_i.funct3, fields_i.rd, fields_i.opcode};
      FMT_I: begin
        if (w_shift) begin
          word_o = {fields_i.funct7, w_imm[4:0], fields_i.rs1,
                    fields_i.funct3, fields_i.rd, fields_i.opcode};
        end else begin
          word_o = {w_imm[11:0], fields_i.rs1,
                    fields_i.funct3, fields_i.rd, fields_i.opcode};
        end
      end
      FMT_S: word_o = {w_imm[11:5], fields_i.rs2, fields_i.rs1,
                       fields_i.funct3, w_imm[4:0], fields_i.opcode};
      FMT_B: word_o = {w_imm[12], w_imm[10:5], fields_i.rs2, fields_i.rs1,
                       fields_i.funct3, w_imm[4:1], w_imm[11], fields_i.opcode};
      FMT_U: word_o = {w_imm[31:12], fields_i.rd, fields_i.opcode};
      FMT_J: word_o = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                       fields_i.rd, fields_i.opcode};
      default: word_o = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A signed field fits when every bit above its sign bit copies the sign bit.
  always_comb begin
    w_imm_ok = 1'b1;
    case (w_fmt)
      FMT_I: begin
        if (w_shift) begin
          w_imm_ok = (w_imm[31:5] == 27'd0);
        end else begin
          w_imm_ok = (&w_imm[31:11]) || !(|w_imm[31:11]);
        end
      end
      FMT_S:   w_imm_ok = (&w_imm[31:11]) || !(|w_imm[31:11]);
      FMT_B:   w_imm_ok = ((&w_imm[31:12]) || !(|w_imm[31:12])) && !w_imm[0];
      FMT_J:   w_imm_ok = ((&w_imm[31:20]) || !(|w_imm[31:20])) && !w_imm[0];
      FMT_U:   w_imm_ok = (w_imm[11:0] == 12'd0);
      default: w_imm_ok = 1'b1;
    endcase
  end
`else
  assign w_imm_ok = 1'b1;
`endif

  assign reject_o = (w_fmt == FMT_ILLEGAL) || !w_imm_ok;

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
//==============================================================================
// inst_encoder : streams encoded RV32I words into instruction memory at an
// auto-incrementing, non-wrapping address. Honours macro IMM_RANGE_CHECK_EN.
// Rev 1.0
//==============================================================================
`default_nettype none

module inst_encoder
  import riscv_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  inst_encoder_if.slave       bus,
  output logic [ADDR_W:0]     word_count,
  output logic                full,
  output logic                err
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  fields_t         w_fields;
  logic [31:0]     w_word;
  logic            w_reject;
  logic            w_accept;

  logic            mem_we_q,    mem_we_d;
  logic [31:0]     mem_addr_q,  mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0] count_q,     count_d;
  logic            err_q,       err_d;
  logic            full_w;

  assign w_fields = '{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                      rs2: bus.in_rs2, funct3: bus.in_funct3,
                      funct7: bus.in_funct7, imm: bus.in_imm};

  inst_pack u_pack (
    .fields_i (w_fields),
    .word_o   (w_word),
    .reject_o (w_reject)
  );

  assign full_w       = (count_q == CAPACITY);
  assign bus.in_ready = !full_w && !start;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // start wins over acceptance; in_ready already masks it, so the bundle stays.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    if (start) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (w_accept) begin
      if (w_reject) begin
        err_d = 1'b1;
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
        mem_wdata_d = w_word;
        count_d     = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign word_count    = count_q;
  assign full          = full_w;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
//==============================================================================
// tb_inst_encoder : known-answer table, corner sequences and random traffic
// against a behavioural model of the encoder (ADDR_W = 2 to reach full often).
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_inst_encoder;

  localparam int          ADDR_W = 2;
  localparam int          CAP    = 4;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    string       name;
    fld_t        f;
    logic [31:0] word;
    bit          legal;
  } vec_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ADDR_W:0] word_count;
  logic            full;
  logic            err;

  inst_encoder_if bus ();

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_cnt    = 0;
  bit          m_err    = 1'b0;
  bit          m_we     = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_shift(input fld_t f);
    return (f.op == 7'h13) && ((f.f3 == 3'd1) || (f.f3 == 3'd5));
  endfunction

  // Reference encoding built from arithmetic field placement and per-bit maps.
  function automatic logic [31:0] ref_encode(input fld_t f);
    logic [31:0] w;
    logic [31:0] imm;
    imm = f.imm;
    w   = 32'(f.op);
    case (f.op)
      7'h33: w = w + 32'(f.rd) * 128 + 32'(f.f3) * 4096 + 32'(f.rs1) * 32768
                   + 32'(f.rs2) * 32'h100000 + 32'(f.f7) * 32'h2000000;
      7'h13, 7'h03, 7'h67: begin
        w = w + 32'(f.rd) * 128 + 32'(f.f3) * 4096 + 32'(f.rs1) * 32768;
        if (is_shift(f)) w = w + (imm % 32) * 32'h100000 + 32'(f.f7) * 32'h2000000;
        else             w = w + (imm % 4096) * 32'h100000;
      end
      7'h23: w = w + 32'(f.f3) * 4096 + 32'(f.rs1) * 32768 + 32'(f.rs2) * 32'h100000
                   + (imm % 32) * 128 + ((imm / 32) % 128) * 32'h2000000;
      7'h63: begin
        w = w + 32'(f.f3) * 4096 + 32'(f.rs1) * 32768 + 32'(f.rs2) * 32'h100000;
        for (int k = 1; k <= 4; k++)  w[7 + k]  = imm[k];
        for (int k = 5; k <= 10; k++) w[20 + k] = imm[k];
        w[7]  = imm[11];
        w[31] = imm[12];
      end
      7'h37, 7'h17: w = w + 32'(f.rd) * 128 + (imm / 4096) * 4096;
      7'h6F: begin
        w = w + 32'(f.rd) * 128;
        for (int k = 1; k <= 10; k++)  w[20 + k] = imm[k];
        w[20] = imm[11];
        for (int k = 12; k <= 19; k++) w[k] = imm[k];
        w[31] = imm[20];
      end
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic bit ref_legal(input fld_t f);
    int si;
    bit ok;
    si = signed'(f.imm);
    case (f.op)
      7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F: ok = 1'b1;
      default: ok = 1'b0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (f.op)
      7'h13, 7'h03, 7'h67, 7'h23: begin
        if (is_shift(f)) ok = (f.imm < 32);
        else             ok = (si >= -2048) && (si <= 2047);
      end
      7'h63:        ok = (si >= -4096) && (si <= 4094) && (f.imm % 2 == 0);
      7'h6F:        ok = (si >= -(1 << 20)) && (si <= (1 << 20) - 2) && (f.imm % 2 == 0);
      7'h37, 7'h17: ok = (f.imm % 4096 == 0);
      default: ;
    endcase
`endif
    return ok;
  endfunction

  function automatic fld_t mkf(input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
    fld_t f;
    f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.f3 = f3; f.f7 = f7; f.imm = imm;
    return f;
  endfunction

  task automatic add_vec(input string n, input fld_t f, input logic [31:0] w, input bit l);
    vec_t v;
    v.name = n; v.f = f; v.word = w; v.legal = l;
    tbl.push_back(v);
  endtask

  function automatic fld_t rand_fld();
    logic [6:0] ops[10];
    fld_t       f;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    f.op  = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 15) == 0) f.op = 7'($urandom);
    f.rd  = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    f.f3  = 3'($urandom); f.f7  = 7'($urandom);
    case ($urandom_range(0, 2))
      0:       f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       f.imm = 32'($urandom_range(0, 31));
      default: f.imm = $urandom;
    endcase
    return f;
  endfunction

  // One clock: drive at negedge, check in_ready, step model, check after posedge.
  task automatic cycle(input bit st, input bit v, input fld_t f,
                       input bit use_tbl, input logic [31:0] tw, input bit tl);
    bit          rdy;
    bit          lg;
    logic [31:0] wexp;
    @(negedge clk);
    start         = st;
    bus.in_valid  = v;
    bus.in_opcode = f.op;  bus.in_rd     = f.rd;  bus.in_rs1 = f.rs1;
    bus.in_rs2    = f.rs2; bus.in_funct3 = f.f3;  bus.in_funct7 = f.f7;
    bus.in_imm    = f.imm;
    #1;
    rdy = (m_cnt != CAP) && !st;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    lg   = use_tbl ? tl : ref_legal(f);
    wexp = use_tbl ? tw : ref_encode(f);
    m_we = 1'b0;
    if (st) begin
      m_cnt = 0;
      m_err = 1'b0;
    end else if (v && rdy) begin
      if (!lg) m_err = 1'b1;
      else begin
        m_we   = 1'b1;
        m_addr = BASE + 32'(m_cnt) * 4;
        m_data = wexp;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk("mem_we", 32'(bus.mem_we), 32'(m_we));
    if (m_we) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_data);
    end
    chk("word_count", 32'(word_count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == CAP));
    chk("err", 32'(err), 32'(m_err));
    start        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic go(input bit st, input bit v, input fld_t f);
    cycle(st, v, f, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fld_t addi, bad;
    addi = mkf(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    bad  = mkf(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);

    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", bus.mem_addr, BASE);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst word_count", 32'(word_count), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);

    // Known-answer table.
    add_vec("addi x1,x0,5", addi, 32'h0050_0093, 1'b1);
    add_vec("sw x2,8(x1)",  mkf(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), 32'h0020_A423, 1'b1);
    add_vec("jal x1,-4",    mkf(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC), 32'hFFDF_F0EF, 1'b1);
    add_vec("add x3,x1,x2", mkf(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0), 32'h0020_81B3, 1'b1);
    add_vec("beq x1,x2,-8", mkf(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8), 32'hFE20_8CE3, 1'b1);
    add_vec("srai x1,x2,3", mkf(7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3), 32'h4031_5093, 1'b1);
    add_vec("addi x1,x0,-1", mkf(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), 32'hFFF0_0093, 1'b1);
    add_vec("lui x5,0x12345000", mkf(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), 32'h1234_52B7, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
    add_vec("addi imm 0x800", mkf(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800), 32'h0, 1'b0);
    add_vec("lui low bits",   mkf(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678), 32'h0, 1'b0);
    add_vec("slli shamt 35",  mkf(7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd35), 32'h0, 1'b0);
`else
    add_vec("addi imm 0x800", mkf(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800), 32'h8000_0093, 1'b1);
    add_vec("lui low bits",   mkf(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678), 32'h1234_52B7, 1'b1);
    add_vec("slli shamt 35",  mkf(7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd35), 32'h0031_1093, 1'b1);
`endif
    foreach (tbl[i]) begin
      if (m_cnt == CAP) go(1'b1, 1'b0, addi);
      cycle(1'b0, 1'b1, tbl[i].f, 1'b1, tbl[i].word, tbl[i].legal);
    end

    // Fill to capacity, hold the fifth bundle, release with start.
    go(1'b1, 1'b0, addi);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b1, addi);
    go(1'b0, 1'b1, addi);
    go(1'b1, 1'b1, addi);
    go(1'b0, 1'b1, addi);

    // Unknown opcode: sticky err, no write, next word at unchanged address.
    go(1'b0, 1'b1, bad);
    go(1'b0, 1'b0, bad);
    go(1'b0, 1'b1, addi);

    // Random traffic with occasional start pulses.
    for (int i = 0; i < 400; i++) begin
      bit st;
      st = ($urandom_range(0, 24) == 0) || ((m_cnt == CAP) && ($urandom_range(0, 2) == 0));
      go(st, ($urandom_range(0, 3) != 0), rand_fld());
    end

    // Asynchronous reset while mem_we is high.
    go(1'b1, 1'b0, addi);
    go(1'b0, 1'b1, addi);
    rst_n = 1'b0;
    #1;
    chk("async rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("async rst word_count", 32'(word_count), 32'd0);
    m_cnt = 0; m_err = 1'b0; m_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst in_ready", 32'(bus.in_ready), 32'd1);
    go(1'b0, 1'b1, addi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
